xbus_responder: RTL and testbench

External-memory bus responder for the 8051 core's multiplexed P0/P2 bus, i.e. the memory-side end of the bus the control unit drives. It latches the low address from P0 on ALE, serves PSEN code fetches and RD data reads by driving P0, and captures WR data. Every access becomes one request on a simple req/ack port toward the backing CODE/XDATA memory model. It runs on the system clock and oversamples the CPU's strobes.

---
 rtl/xbus_pkg.sv | 33 +++
 rtl/xbus_edge_sync.sv | 47 ++++
 rtl/xbus_responder.sv | 187 ++++++++++++++++++
 tb/tb_xbus_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared constants for the 8051 external-bus responder: FSM state encoding,
// memory space codes and the idle levels of the bus strobes.
package xbus_pkg;

    typedef logic [2:0] xbus_state_t;

    localparam xbus_state_t StIdle    = 3'd0;
    localparam xbus_state_t StRdReq   = 3'd1;
    localparam xbus_state_t StRdDrive = 3'd2;
    localparam xbus_state_t StRdAbort = 3'd3;
    localparam xbus_state_t StWrCapt  = 3'd4;
    localparam xbus_state_t StWrReq   = 3'd5;

    localparam logic XBUS_SPACE_CODE  = 1'b0;
    localparam logic XBUS_SPACE_XDATA = 1'b1;

    localparam logic XBUS_ALE_IDLE    = 1'b0;
    localparam logic XBUS_STROBE_IDLE = 1'b1;

    // Bit positions in the packed strobe vector {ale, psen_n, rd_n, wr_n}.
    localparam int unsigned XBUS_PIN_ALE  = 3;
    localparam int unsigned XBUS_PIN_PSEN = 2;
    localparam int unsigned XBUS_PIN_RD   = 1;
    localparam int unsigned XBUS_PIN_WR   = 0;

    localparam logic [3:0] XBUS_PIN_RST = {XBUS_ALE_IDLE, {3{XBUS_STROBE_IDLE}}};

    // True when more than one bit is set.
    function automatic logic multi_hot(input logic [2:0] v);
        return (v & (v - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/xbus_edge_sync.sv
// Optional 2-flop synchronizer followed by a rise/fall detector.
// Synchronizers are present only when XBUS_SYNC_EN is defined.
module xbus_edge_sync #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q,
    output logic [Width-1:0] rise,
    output logic [Width-1:0] fall
);

    logic [Width-1:0] prev_q;

`ifdef XBUS_SYNC_EN
    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= ResetVal;
            sync2_q <= ResetVal;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;
`else
    assign q = d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= ResetVal;
        end else begin
            prev_q <= q;
        end
    end

    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/xbus_responder.sv
// Memory-side responder for the 8051 multiplexed P0/P2 bus; turns each PSEN/RD/WR
// access into one req/ack memory request. Define XBUS_SYNC_EN for asynchronous buses.
module xbus_responder
    import xbus_pkg::*;
#(
    parameter int unsigned DEPTH_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ale,
    input  logic               psen_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic [7:0]         p0_in,
    input  logic [7:0]         p2_in,
    output logic [7:0]         p0_out,
    output logic               p0_oe,
    output logic               mem_req,
    output logic               mem_space,
    output logic               mem_we,
    output logic [DEPTH_W-1:0] mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    input  logic               mem_ack,
    output logic               bus_err,
    output logic               busy
);

    logic [3:0]  pin_raw, pin_q, pin_rise, pin_fall;
    logic [15:0] bus_raw, bus_q, unused_bus_rise, unused_bus_fall;
    logic        unused_ale_rise;

    assign pin_raw = {ale, psen_n, rd_n, wr_n};
    assign bus_raw = {p2_in, p0_in};

    xbus_edge_sync #(
        .Width    (4),
        .ResetVal (XBUS_PIN_RST)
    ) u_pin_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin_raw),
        .q     (pin_q),
        .rise  (pin_rise),
        .fall  (pin_fall)
    );

    // Data pins share the strobe delay so address/data stay aligned with the edges.
    xbus_edge_sync #(
        .Width    (16),
        .ResetVal (16'h0000)
    ) u_bus_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus_raw),
        .q     (bus_q),
        .rise  (unused_bus_rise),
        .fall  (unused_bus_fall)
    );

    assign unused_ale_rise = pin_rise[XBUS_PIN_ALE];

    xbus_state_t        state_q, state_d;
    logic [DEPTH_W-1:0] addr_lat_q, addr_lat_d;
    logic               space_q, space_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         p0_out_q, p0_out_d;
    logic               bus_err_q, bus_err_d;
    logic [2:0]         pend_q, pend_d;

    logic [2:0] strobe_fall, req_fall;
    logic       ale_fall, any_fall, sel_lvl, sel_rise;

    assign strobe_fall = pin_fall[2:0];
    assign ale_fall    = pin_fall[XBUS_PIN_ALE];
    assign any_fall    = |pin_fall;
    // Falls seen while RD_DRIVE was finishing are replayed once back in IDLE.
    assign req_fall    = strobe_fall | pend_q;
    assign sel_lvl     = (space_q == XBUS_SPACE_XDATA) ? pin_q[XBUS_PIN_RD] :
                                                         pin_q[XBUS_PIN_PSEN];
    assign sel_rise    = (space_q == XBUS_SPACE_XDATA) ? pin_rise[XBUS_PIN_RD] :
                                                         pin_rise[XBUS_PIN_PSEN];

    always_comb begin
        state_d    = state_q;
        addr_lat_d = addr_lat_q;
        space_d    = space_q;
        wdata_d    = wdata_q;
        p0_out_d   = p0_out_q;
        bus_err_d  = 1'b0;
        pend_d     = pend_q;

        case (state_q)
            StIdle: begin
                pend_d = 3'b000;
                if (ale_fall) begin
                    addr_lat_d = bus_q[DEPTH_W-1:0];
                end
                bus_err_d = multi_hot(req_fall);
                if (req_fall[XBUS_PIN_PSEN]) begin
                    state_d = StRdReq;
                    space_d = XBUS_SPACE_CODE;
                end else if (req_fall[XBUS_PIN_RD]) begin
                    state_d = StRdReq;
                    space_d = XBUS_SPACE_XDATA;
                end else if (req_fall[XBUS_PIN_WR]) begin
                    state_d = StWrCapt;
                    space_d = XBUS_SPACE_XDATA;
                    wdata_d = bus_q[7:0];
                end
            end
            StRdReq: begin
                bus_err_d = any_fall;
                if (mem_ack) begin
                    p0_out_d = mem_rdata;
                    state_d  = StRdDrive;
                end else if (sel_rise) begin
                    state_d = StRdAbort;
                end
            end
            StRdDrive: begin
                if (sel_lvl == XBUS_STROBE_IDLE) begin
                    state_d   = StIdle;
                    pend_d    = strobe_fall;
                    bus_err_d = ale_fall;
                end else begin
                    bus_err_d = any_fall;
                end
            end
            StRdAbort: begin
                bus_err_d = any_fall;
                if (mem_ack) begin
                    state_d   = StIdle;
                    bus_err_d = 1'b1;
                end
            end
            StWrCapt: begin
                bus_err_d = any_fall;
                if (pin_rise[XBUS_PIN_WR]) begin
                    state_d = StWrReq;
                end else begin
                    wdata_d = bus_q[7:0];
                end
            end
            StWrReq: begin
                bus_err_d = any_fall;
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_lat_q <= '0;
            space_q    <= XBUS_SPACE_CODE;
            wdata_q    <= 8'h00;
            p0_out_q   <= 8'h00;
            bus_err_q  <= 1'b0;
            pend_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            addr_lat_q <= addr_lat_d;
            space_q    <= space_d;
            wdata_q    <= wdata_d;
            p0_out_q   <= p0_out_d;
            bus_err_q  <= bus_err_d;
            pend_q     <= pend_d;
        end
    end

    // Request fields come straight from registers that only move outside request
    // states, so they are stable for the whole req/ack handshake.
    assign mem_req   = (state_q == StRdReq) || (state_q == StRdAbort) || (state_q == StWrReq);
    assign mem_we    = (state_q == StWrReq);
    assign mem_space = space_q;
    assign mem_addr  = addr_lat_q;
    assign mem_wdata = wdata_q;
    assign p0_out    = p0_out_q;
    assign p0_oe     = (state_q == StRdDrive);
    assign bus_err   = bus_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_xbus_responder.sv
// Directed bench for xbus_responder: per-edge expectations built from the bus timing
// rules, checked every cycle, plus literal spot checks per scenario.
module tb_xbus_responder;

    localparam int N = 160;
`ifdef XBUS_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, ale, psen_n, rd_n, wr_n, mem_ack;
    logic [7:0]  p0_in, p2_in, mem_rdata;
    logic [7:0]  p0_out, mem_wdata;
    logic        p0_oe, mem_req, mem_space, mem_we, bus_err, busy;
    logic [15:0] mem_addr;

    xbus_responder #(
        .DEPTH_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ale       (ale),
        .psen_n    (psen_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .p0_in     (p0_in),
        .p2_in     (p2_in),
        .p0_out    (p0_out),
        .p0_oe     (p0_oe),
        .mem_req   (mem_req),
        .mem_space (mem_space),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected value of each output in the interval after edge n.
    bit          e_req[N], e_oe[N], e_busy[N], e_err[N], e_we[N], e_space[N];
    bit          chk_wd[N], chk_p0[N], chk_rst[N];
    logic [15:0] e_addr[N];
    logic [7:0]  e_wd[N], e_p0[N];

    // Monitor summaries for the literal checks.
    int          req_rise_n, cnt_req, cnt_xreq, cnt_oe, cnt_err;
    logic [15:0] mon_addr;
    logic [7:0]  mon_p0, mon_wd;
    logic        mon_space, mon_we, prev_req;

    task automatic chk(input string nm, input int n, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: actual %h, required %h", nm, n, act, exp);
        end
    endtask

    // Read strobe low from pin edge e to r-1, ack sampled at edge a.
    function automatic void m_read(int e, int a, int r, logic [15:0] addr, logic sp,
                                   logic [7:0] d);
        int es = e + L;
        int rs = r + L;
        for (int n = es; n < a && n < N; n++) begin
            e_req[n] = 1'b1; e_addr[n] = addr; e_space[n] = sp;
        end
        if (rs > a) begin
            for (int n = a; n < rs && n < N; n++) begin
                e_oe[n] = 1'b1; e_p0[n] = d; chk_p0[n] = 1'b1;
            end
            for (int n = es; n < rs && n < N; n++) e_busy[n] = 1'b1;
        end else begin
            e_err[a] = 1'b1;
            for (int n = es; n < a && n < N; n++) e_busy[n] = 1'b1;
        end
    endfunction

    function automatic void m_write(int e, int r, int a, logic [15:0] addr, logic [7:0] wd);
        int es = e + L;
        int rs = r + L;
        for (int n = rs; n < a; n++) begin
            e_req[n] = 1'b1; e_we[n] = 1'b1; e_space[n] = 1'b1;
            e_addr[n] = addr; e_wd[n] = wd; chk_wd[n] = 1'b1;
        end
        for (int n = es; n < a; n++) e_busy[n] = 1'b1;
    endfunction

    function automatic void m_err(int n);
        e_err[n + L] = 1'b1;
    endfunction

    function automatic void m_reset(int x);
        for (int n = x; n < N; n++) begin
            e_req[n] = 1'b0; e_oe[n] = 1'b0; e_busy[n] = 1'b0; e_err[n] = 1'b0;
            e_we[n] = 1'b0; chk_wd[n] = 1'b0; chk_p0[n] = 1'b0;
        end
        chk_rst[x] = 1'b1; chk_p0[x] = 1'b1; e_p0[x] = 8'h00;
    endfunction

    task automatic clr_mon();
        cnt_req = 0; cnt_xreq = 0; cnt_oe = 0; cnt_err = 0; req_rise_n = -1;
    endtask

    // Compare process: every edge, 1 time unit after it.
    initial begin
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (cyc < N) begin
                chk("mem_req", cyc, 16'(mem_req), 16'(e_req[cyc]));
                chk("p0_oe", cyc, 16'(p0_oe), 16'(e_oe[cyc]));
                chk("busy", cyc, 16'(busy), 16'(e_busy[cyc]));
                chk("bus_err", cyc, 16'(bus_err), 16'(e_err[cyc]));
                chk("mem_we", cyc, 16'(mem_we), 16'(e_we[cyc]));
                if (e_req[cyc]) begin
                    chk("mem_addr", cyc, mem_addr, e_addr[cyc]);
                    chk("mem_space", cyc, 16'(mem_space), 16'(e_space[cyc]));
                end
                if (chk_wd[cyc]) chk("mem_wdata", cyc, 16'(mem_wdata), 16'(e_wd[cyc]));
                if (chk_p0[cyc]) chk("p0_out", cyc, 16'(p0_out), 16'(e_p0[cyc]));
                if (chk_rst[cyc]) begin
                    chk("rst_addr", cyc, mem_addr, 16'h0000);
                    chk("rst_space", cyc, 16'(mem_space), 16'h0000);
                    chk("rst_wdata", cyc, 16'(mem_wdata), 16'h0000);
                end
            end
            if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                req_rise_n = cyc; mon_addr = mem_addr; mon_space = mem_space;
                mon_we = mem_we; mon_wd = mem_wdata;
            end
            if (mem_req === 1'b1) cnt_req++;
            if (mem_req === 1'b1 && mem_space === 1'b1) cnt_xreq++;
            if (p0_oe === 1'b1) begin cnt_oe++; mon_p0 = p0_out; end
            if (bus_err === 1'b1) cnt_err++;
            prev_req = mem_req;
        end
    end

    // Return at the falling edge just before edge n, so values set now are sampled at n.
    task automatic go(input int n);
        if (cyc > n - 1) begin
            fails++;
            $display("FAIL schedule: edge %0d already passed (now %0d)", n, cyc);
        end
        while (cyc < n - 1) @(negedge clk);
    endtask

    task automatic ack_at(input int a, input logic [7:0] d);
        go(a);
        mem_ack = 1'b1; mem_rdata = d;
        go(a + 1);
        mem_ack = 1'b0; mem_rdata = 8'h00;
    endtask

    // ALE high at edges n, n+1 and low at n+2 with the address still on the pins.
    task automatic addr_phase(input int n, input logic [15:0] a);
        go(n);
        ale = 1'b1; p2_in = a[15:8]; p0_in = a[7:0];
        go(n + 2);
        ale = 1'b0;
        go(n + 3);
        p0_in = 8'hFF;
    endtask

    initial begin
        reset = 1'b1; ale = 1'b0; psen_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        p0_in = 8'hFF; p2_in = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        for (int n = 1; n <= 3; n++) begin
            chk_rst[n] = 1'b1; chk_p0[n] = 1'b1; e_p0[n] = 8'h00;
        end
        clr_mon();
        go(4);
        reset = 1'b0;

        // Code fetch at 16'h1234, zero-wait-plus-one memory.
        m_read(10, 12 + L, 16, 16'h1234, 1'b0, 8'hA5);
        clr_mon();
        addr_phase(6, 16'h1234);
        go(10); psen_n = 1'b0;
        fork ack_at(12 + L, 8'hA5); join_none
        go(16); psen_n = 1'b1;
        go(19);
        chk("s1_req_edge", cyc, 16'(req_rise_n), 16'(10 + L));
        chk("s1_req_cycles", cyc, 16'(cnt_req), 16'd2);
        chk("s1_addr", cyc, mon_addr, 16'h1234);
        chk("s1_space", cyc, 16'(mon_space), 16'h0000);
        chk("s1_p0", cyc, 16'(mon_p0), 16'h00A5);
        chk("s1_oe_cycles", cyc, 16'(cnt_oe), 16'd4);

        // XDATA write; only the last low-cycle P0 value counts.
        m_write(24, 28, 29 + L, 16'h00F0, 8'h5A);
        clr_mon();
        addr_phase(20, 16'h00F0);
        go(24); wr_n = 1'b0; p0_in = 8'h11;
        go(25); p0_in = 8'h22;
        go(26); p0_in = 8'h33;
        go(27); p0_in = 8'h5A;
        go(28); wr_n = 1'b1; p0_in = 8'hFF;
        fork ack_at(29 + L, 8'h00); join_none
        go(31);
        chk("s2_wdata", cyc, 16'(mon_wd), 16'h005A);
        chk("s2_we", cyc, 16'(mon_we), 16'h0001);
        chk("s2_space", cyc, 16'(mon_space), 16'h0001);
        chk("s2_addr", cyc, mon_addr, 16'h00F0);
        chk("s2_req_cycles", cyc, 16'(cnt_req), 16'd1);

        // Late ack: rd_n released before the memory answers.
        m_read(36, 42 + L, 38, 16'h0456, 1'b1, 8'hEE);
        clr_mon();
        addr_phase(32, 16'h0456);
        go(36); rd_n = 1'b0;
        fork ack_at(42 + L, 8'hEE); join_none
        go(38); rd_n = 1'b1;
        go(45);
        chk("s3_oe_cycles", cyc, 16'(cnt_oe), 16'd0);
        chk("s3_err_pulses", cyc, 16'(cnt_err), 16'd1);
        chk("s3_req_cycles", cyc, 16'(cnt_req), 16'd6);

        // psen_n and rd_n fall together: CODE wins, one error pulse.
        m_read(50, 51 + L, 54, 16'hBEEF, 1'b0, 8'h3C);
        m_err(50);
        clr_mon();
        addr_phase(46, 16'hBEEF);
        go(50); psen_n = 1'b0; rd_n = 1'b0;
        fork ack_at(51 + L, 8'h3C); join_none
        go(54); psen_n = 1'b1; rd_n = 1'b1;
        go(57);
        chk("s4_err_pulses", cyc, 16'(cnt_err), 16'd1);
        chk("s4_xdata_req", cyc, 16'(cnt_xreq), 16'd0);
        chk("s4_space", cyc, 16'(mon_space), 16'h0000);
        chk("s4_addr", cyc, mon_addr, 16'hBEEF);
        chk("s4_p0", cyc, 16'(mon_p0), 16'h003C);

        // Reset while driving P0, then a fresh fetch.
        m_read(62, 63 + L, N + 100, 16'h2222, 1'b0, 8'h77);
        m_reset(65 + L);
        m_read(74, 77 + L, 82, 16'h0F0F, 1'b0, 8'hC3);
        clr_mon();
        addr_phase(58, 16'h2222);
        go(62); psen_n = 1'b0;
        fork ack_at(63 + L, 8'h77); join_none
        go(65 + L); reset = 1'b1; psen_n = 1'b1;
        go(66 + L); reset = 1'b0;
        chk("s5_rst_oe", cyc, 16'(p0_oe), 16'h0000);
        chk("s5_rst_req", cyc, 16'(mem_req), 16'h0000);
        chk("s5_rst_busy", cyc, 16'(busy), 16'h0000);
        addr_phase(70, 16'h0F0F);
        go(74); psen_n = 1'b0;
        fork ack_at(77 + L, 8'hC3); join_none
        go(82); psen_n = 1'b1;
        go(86);
        chk("s5_p0", cyc, 16'(mon_p0), 16'h00C3);
        chk("s5_addr", cyc, mon_addr, 16'h0F0F);

        // ALE pulse during RD_DRIVE: error, latched address kept.
        m_read(90, 91 + L, 96, 16'h0F0F, 1'b1, 8'h99);
        m_err(95);
        m_read(100, 101 + L, 104, 16'h0F0F, 1'b0, 8'h11);
        clr_mon();
        go(90); rd_n = 1'b0;
        fork ack_at(91 + L, 8'h99); join_none
        addr_phase(93, 16'h5555);
        go(96); rd_n = 1'b1;
        go(100); psen_n = 1'b0;
        fork ack_at(101 + L, 8'h11); join_none
        go(104); psen_n = 1'b1;
        go(108);
        chk("s6_err_pulses", cyc, 16'(cnt_err), 16'd1);
        chk("s6_addr", cyc, mon_addr, 16'h0F0F);
        chk("s6_p0", cyc, 16'(mon_p0), 16'h0011);

        go(115);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
